// File: rtl/axi4l_cmd_master_pkg.sv
// Shared constants and FSM state type for the single-outstanding AXI4-lite command master.
package axi4l_cmd_master_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RRESP = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // States in which a bus transaction is in flight and the timeout counter runs.
    function automatic logic is_active(input state_t s);
        return (s == ST_WADDR) || (s == ST_WRESP) || (s == ST_RADDR) || (s == ST_RRESP);
    endfunction

endpackage

// File: rtl/axi4l_cmd_master_if.sv
// AXI4-lite bus bundle (32-bit data) with master and slave views.
interface axi4l_cmd_master_if #(
    parameter int P_AW = 32
);
    logic [P_AW-1:0] awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [P_AW-1:0] araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    // Every channel: a transfer happens on a rising edge where valid && ready;
    // valid, once raised, holds with stable payload until that edge.
    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_cmd_master_timeout_cnt.sv
// Transaction watchdog: counts enabled cycles since clear, flags the P_LIMIT-th one.
module axi4l_timeout_cnt #(
    parameter int P_LIMIT = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (P_LIMIT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{aclk, aresetn, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int              CW   = $clog2(P_LIMIT + 1);
            localparam logic [CW-1:0]   LAST = CW'(P_LIMIT - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && (cnt != LAST)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Asserted during the P_LIMIT-th enabled cycle after clear.
            assign expired = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-lite master: one command in, one AXI read or write, one response out.
module axi4l_cmd_master
    import axi4l_cmd_master_pkg::*;
#(
    parameter int P_AW      = 32,
    parameter int P_TIMEOUT = 1024
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    // command port: accepted on a rising edge where cmd_valid && cmd_ready
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [P_AW-1:0]      cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    // response port: held stable until rsp_valid && rsp_ready
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 rsp_timeout,
    axi4l_cmd_master_if.master   axi,
    output state_t               dbg_state
);

    state_t          state_q, state_d;
    logic            aw_valid_q, aw_valid_d;
    logic            w_valid_q, w_valid_d;
    logic            ar_valid_q, ar_valid_d;
    logic            b_ready_q, b_ready_d;
    logic            r_ready_q, r_ready_d;
    logic            owed_q, owed_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic [P_AW-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q, we_d;

    logic            accept;
    logic            timer_en;
    logic            expired;
    logic            timeout_hit;
    logic            b_hs;
    logic            r_hs;

    assign cmd_ready = (state_q == ST_IDLE) && aresetn;
    assign accept    = cmd_valid && cmd_ready;
    assign timer_en  = is_active(state_q);
    assign b_hs      = b_ready_q && axi.bvalid;
    assign r_hs      = r_ready_q && axi.rvalid;

    axi4l_timeout_cnt #(
        .P_LIMIT (P_TIMEOUT)
    ) u_timeout (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (accept),
        .enable  (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        ar_valid_d    = ar_valid_q;
        owed_d        = owed_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        we_d          = we_q;
        timeout_hit   = 1'b0;

        // Channel handshakes retire independently in every state, DRAIN included.
        if (aw_valid_q && axi.awready) aw_valid_d = 1'b0;
        if (w_valid_q && axi.wready)   w_valid_d  = 1'b0;
        if (ar_valid_q && axi.arready) ar_valid_d = 1'b0;
        if (b_hs || r_hs)              owed_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d        = cmd_addr;
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    we_d          = cmd_we;
                    aw_valid_d    = cmd_we;
                    w_valid_d     = cmd_we;
                    ar_valid_d    = !cmd_we;
                    owed_d        = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = cmd_we ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (expired)                         timeout_hit = 1'b1;
                else if (!aw_valid_d && !w_valid_d)  state_d     = ST_WRESP;
            end
            ST_WRESP: begin
                // A response landing in the expiry cycle still completes normally.
                if (b_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = axi.bresp;
                    rsp_rdata_d = '0;
                    state_d     = ST_DONE;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_RADDR: begin
                if (expired)          timeout_hit = 1'b1;
                else if (!ar_valid_d) state_d     = ST_RRESP;
            end
            ST_RRESP: begin
                if (r_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = axi.rresp;
                    rsp_rdata_d = axi.rdata;
                    state_d     = ST_DONE;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Leave only once the slave has answered and the timeout report was taken.
                if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
                if (!rsp_valid_d && !owed_d)  state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_hit) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = SLVERR;
            rsp_rdata_d   = '0;
            state_d       = ST_DRAIN;
        end

        // Readies follow from what is still owed once address/data beats are gone.
        b_ready_d = ((state_d == ST_WRESP) || (state_d == ST_DRAIN)) && we_d && owed_d
                    && !aw_valid_d && !w_valid_d;
        r_ready_d = ((state_d == ST_RRESP) || (state_d == ST_DRAIN)) && !we_d && owed_d
                    && !ar_valid_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            ar_valid_q    <= 1'b0;
            b_ready_q     <= 1'b0;
            r_ready_q     <= 1'b0;
            owed_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            ar_valid_q    <= ar_valid_d;
            b_ready_q     <= b_ready_d;
            r_ready_q     <= r_ready_d;
            owed_q        <= owed_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            we_q          <= we_d;
        end
    end

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = aw_valid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = w_valid_q;
    assign axi.bready  = b_ready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = ar_valid_q;
    assign axi.rready  = r_ready_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Directed bench for axi4l_cmd_master against an AXI4-lite slave model with programmable delays.
`timescale 1ns/1ps
module tb_axi4l_cmd_master;
    import axi4l_cmd_master_pkg::*;

    localparam int P_AW      = 32;
    localparam int P_TIMEOUT = 8;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we    = 1'b0;
    logic [P_AW-1:0] cmd_addr  = '0;
    logic [31:0]     cmd_wdata = '0;
    logic [3:0]      cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    state_t          dbg_state;

    axi4l_cmd_master_if #(.P_AW(P_AW)) axi ();

    axi4l_cmd_master #(.P_AW(P_AW), .P_TIMEOUT(P_TIMEOUT)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi         (axi),
        .dbg_state   (dbg_state)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit          b_hold = 1'b0, r_hold = 1'b0;
    logic [1:0]  cfg_bresp = OKAY, cfg_rresp = OKAY;
    logic [31:0] cfg_rdata = '0;

    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit          aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    logic aw_hs, w_hs, ar_hs;
    assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_dly);
    assign axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= OKAY;
            axi.rvalid <= 1'b0; axi.rresp <= OKAY; axi.rdata <= '0;
        end else begin
            if (aw_hs) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_beats <= aw_beats + 1;
                aw_hs_cyc <= cyc + 1; cap_awaddr <= axi.awaddr;
            end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_cnt <= 0; w_got <= 1'b1; w_beats <= w_beats + 1;
                w_hs_cyc <= cyc + 1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb;
            end else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (!b_pend && (aw_got || aw_hs) && (w_got || w_hs)) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (b_pend && !axi.bvalid && !b_hold) begin
                if (b_cnt >= b_dly) begin axi.bvalid <= 1'b1; axi.bresp <= cfg_bresp; end
                else b_cnt <= b_cnt + 1;
            end
            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0; b_pend <= 1'b0; b_beats <= b_beats + 1;
            end
            if (ar_hs) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; ar_beats <= ar_beats + 1;
                ar_hs_cyc <= cyc + 1; cap_araddr <= axi.araddr;
            end else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
            if (r_pend && !axi.rvalid && !r_hold) begin
                if (r_cnt >= r_dly) begin
                    axi.rvalid <= 1'b1; axi.rresp <= cfg_rresp; axi.rdata <= cfg_rdata;
                end else r_cnt <= r_cnt + 1;
            end
            if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0; r_pend <= 1'b0; r_beats <= r_beats + 1;
            end
        end
    end

    // ---------------- checking / driver tasks ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int acc);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        check("cmd_accept_wait", 32'(n < 50), 32'd1);
        @(posedge aclk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int acc, output logic [31:0] rd, output logic [1:0] rs,
                           output logic to, output int lat);
        int n = 0;
        @(negedge aclk);
        while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
        check("rsp_wait", 32'(n < 100), 32'd1);
        lat = cyc - acc; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc, lat, n, b0, aw0, w0, r0;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;

        // reset values
        repeat (3) @(posedge aclk);
        #1;
        check("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check("rst_awvalid", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rst_cmd_ready_high", 32'(cmd_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_rsp", 32'({rsp_rdata, rsp_resp, rsp_timeout}), 32'd0);
        check("rst_prot", 32'({axi.awprot, axi.arprot}), 32'd0);

        // write, slave ready in the same cycle on AW and W
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("wr1_resp", 32'(rs), 32'(OKAY));
        check("wr1_rdata", rd, 32'd0);
        check("wr1_timeout", 32'(to), 32'd0);
        check("wr1_awaddr", cap_awaddr, 32'h10);
        check("wr1_wdata", cap_wdata, 32'hDEADBEEF);
        check("wr1_wstrb", 32'(cap_wstrb), 32'hF);
        check("wr1_aw_cyc", 32'(aw_hs_cyc), 32'(acc + 1));
        check("wr1_w_cyc", 32'(w_hs_cyc), 32'(acc + 1));
        check("wr1_beats", 32'({aw_beats - aw0, w_beats - w0, b_beats - b0}), {32'd1, 32'd1, 32'd1});

        // read, arready three cycles late
        ar_dly = 3; cfg_rdata = 32'h12345678; cfg_rresp = OKAY;
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("rd1_rdata", rd, 32'h12345678);
        check("rd1_resp", 32'(rs), 32'(OKAY));
        check("rd1_timeout", 32'(to), 32'd0);
        check("rd1_araddr", cap_araddr, 32'h20);
        check("rd1_ar_cyc", 32'(ar_hs_cyc), 32'(acc + 4));
        ar_dly = 0;

        // write, W accepted two cycles before AW
        aw_dly = 2; aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        do_cmd(1'b1, 32'h30, 32'h0BADF00D, 4'h5, acc);
        @(negedge aclk);
        @(negedge aclk);
        check("wfirst_wvalid_dropped", 32'(axi.wvalid), 32'd0);
        check("wfirst_awvalid_held", 32'(axi.awvalid), 32'd1);
        get_rsp(acc, rd, rs, to, lat);
        check("wfirst_w_cyc", 32'(w_hs_cyc), 32'(acc + 1));
        check("wfirst_aw_cyc", 32'(aw_hs_cyc), 32'(acc + 3));
        check("wfirst_beats", 32'({aw_beats - aw0, w_beats - w0, b_beats - b0}), {32'd1, 32'd1, 32'd1});
        check("wfirst_resp", 32'(rs), 32'(OKAY));
        aw_dly = 0;

        // read answered with DECERR
        cfg_rresp = DECERR; cfg_rdata = 32'hCAFEF00D;
        do_cmd(1'b0, 32'h24, 32'h0, 4'h0, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("decerr_resp", 32'(rs), 32'(DECERR));
        check("decerr_timeout", 32'(to), 32'd0);
        check("decerr_rdata", rd, 32'hCAFEF00D);
        cfg_rresp = OKAY;

        // hung write: timeout, then late bvalid absorbed
        b_hold = 1'b1; b0 = b_beats;
        do_cmd(1'b1, 32'h40, 32'h55, 4'h3, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("to_latency", 32'(lat), 32'd8);
        check("to_flag", 32'(to), 32'd1);
        check("to_resp", 32'(rs), 32'(SLVERR));
        check("to_rdata", rd, 32'd0);
        check("to_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        check("to_bready_held", 32'(axi.bready), 32'd1);
        repeat (3) @(negedge aclk);
        check("to_cmd_ready_low", 32'(cmd_ready), 32'd0);
        b_hold = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge aclk); n++; end
        check("to_drain_done", 32'(n < 20), 32'd1);
        check("to_no_second_rsp", 32'(rsp_valid), 32'd0);
        check("to_late_b_absorbed", 32'(b_beats - b0), 32'd1);

        // normal read after the drain
        cfg_rdata = 32'hA5A5A5A5;
        do_cmd(1'b0, 32'h44, 32'h0, 4'h0, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("post_to_rdata", rd, 32'hA5A5A5A5);
        check("post_to_resp", 32'({rs, to}), {29'd0, OKAY, 1'b0});

        // response handshake in the expiry cycle completes normally
        b_dly = 5;
        do_cmd(1'b1, 32'h48, 32'h1, 4'h1, acc);
        get_rsp(acc, rd, rs, to, lat);
        check("edge_latency", 32'(lat), 32'd8);
        check("edge_no_timeout", 32'(to), 32'd0);
        check("edge_resp", 32'(rs), 32'(OKAY));
        b_dly = 0;

        // reset while waiting in RRESP
        r_hold = 1'b1; r0 = r_beats;
        do_cmd(1'b0, 32'h80, 32'h0, 4'h0, acc);
        @(negedge aclk);
        @(negedge aclk);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_RRESP));
        check("rst_mid_rready_before", 32'(axi.rready), 32'd1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("rst_mid_rready_after", 32'(axi.rready), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge aclk);
        aresetn = 1'b1; r_hold = 1'b0;
        @(posedge aclk); #1;
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(posedge aclk);
        #1;
        check("rst_mid_no_completion", 32'({rsp_valid, 31'(r_beats - r0)}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
